// File: rtl/interrupt_controller_if.sv
// Purpose: CPU bus and interrupt handshake bundle for interrupt_controller.
// Signals:
//   bus_addr[11:0], bus_read_req, bus_write_req, bus_write_data[3:0] : CPU -> controller
//   bus_read_data[3:0], bus_hit                                      : controller -> CPU (combinational)
//   interrupt_enable, interrupt_ack                                  : core -> controller
//   interrupt_req, interrupt_vector[12:0]                            : controller -> core
// Modports: master = CPU/core side, slave = interrupt controller side.
interface interrupt_controller_if;
  logic [11:0] bus_addr;
  logic        bus_read_req;
  logic        bus_write_req;
  logic [3:0]  bus_write_data;
  logic [3:0]  bus_read_data;
  logic        bus_hit;
  logic        interrupt_enable;
  logic        interrupt_ack;
  logic        interrupt_req;
  logic [12:0] interrupt_vector;

  modport master (
    output bus_addr, bus_read_req, bus_write_req, bus_write_data,
    output interrupt_enable, interrupt_ack,
    input  bus_read_data, bus_hit, interrupt_req, interrupt_vector
  );

  modport slave (
    input  bus_addr, bus_read_req, bus_write_req, bus_write_data,
    input  interrupt_enable, interrupt_ack,
    output bus_read_data, bus_hit, interrupt_req, interrupt_vector
  );
endinterface

// File: rtl/interrupt_controller.sv
// Purpose: six-source interrupt controller with read-to-clear factor registers
//   (F00..F05), read/write mask registers (F10..F15), fixed-priority
//   arbitration and an IDLE/REQUEST/SERVICE handshake with the core.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   clock_timer_set[3:0], stopwatch_set[1:0], prog_timer_set, serial_set,
//   k0_set, k1_set        : single-cycle factor-set pulses
//   bus                   : interrupt_controller_if.slave (CPU bus + interrupt handshake)
// Configuration: define INTERRUPT_SERIAL_EN to include the serial source (F03/F13,
//   vector 0x10A). Without it those registers read 0 and serial_set is ignored.
module interrupt_controller (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   clock_timer_set,
  input  logic [1:0]                   stopwatch_set,
  input  logic                         prog_timer_set,
  input  logic                         serial_set,
  input  logic                         k0_set,
  input  logic                         k1_set,
  interrupt_controller_if.slave        bus
);

  localparam int unsigned NUM_SRC = 6;
  localparam int unsigned SRC_W   = 3;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned VEC_W   = 13;

`ifdef INTERRUPT_SERIAL_EN
  localparam bit SERIAL_EN = 1'b1;
`else
  localparam bit SERIAL_EN = 1'b0;
`endif

  // Source index == low address nibble of its factor/mask register
  localparam logic [SRC_W-1:0] SRC_CLK = 3'd0;
  localparam logic [SRC_W-1:0] SRC_SW  = 3'd1;
  localparam logic [SRC_W-1:0] SRC_PT  = 3'd2;
  localparam logic [SRC_W-1:0] SRC_SER = 3'd3;
  localparam logic [SRC_W-1:0] SRC_K0  = 3'd4;
  localparam logic [SRC_W-1:0] SRC_K1  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVICE
  } state_e;

  // Implemented bits of each factor/mask register
  function automatic logic [NIB_W-1:0] valid_bits(input logic [SRC_W-1:0] idx);
    case (idx)
      SRC_CLK: valid_bits = 4'hF;
      SRC_SW:  valid_bits = 4'h3;
      SRC_PT:  valid_bits = 4'h1;
      SRC_SER: valid_bits = SERIAL_EN ? 4'h1 : 4'h0;
      SRC_K0:  valid_bits = 4'h1;
      SRC_K1:  valid_bits = 4'h1;
      default: valid_bits = 4'h0;
    endcase
  endfunction

  // Service address for each source
  function automatic logic [VEC_W-1:0] vector_of(input logic [SRC_W-1:0] idx);
    case (idx)
      SRC_CLK: vector_of = 13'h0102;
      SRC_SW:  vector_of = 13'h0104;
      SRC_K0:  vector_of = 13'h0106;
      SRC_K1:  vector_of = 13'h0108;
      SRC_SER: vector_of = 13'h010A;
      SRC_PT:  vector_of = 13'h010C;
      default: vector_of = 13'h0000;
    endcase
  endfunction

  state_e                               state_q, state_d;
  logic [SRC_W-1:0]                     src_q, src_d;
  logic [VEC_W-1:0]                     vector_q, vector_d;
  logic [NUM_SRC-1:0][NIB_W-1:0]        factor_q, factor_d;
  logic [NUM_SRC-1:0][NIB_W-1:0]        mask_q, mask_d;
  logic [NUM_SRC-1:0][NIB_W-1:0]        set_bits;
  logic [NUM_SRC-1:0]                   pending;
  logic                                 any_pending;
  logic [SRC_W-1:0]                     best_src;
  logic                                 fac_sel;
  logic                                 msk_sel;
  logic [SRC_W-1:0]                     sel_idx;

  // Address decode: 0xF00..0xF05 factors, 0xF10..0xF15 masks
  assign fac_sel     = (bus.bus_addr[11:4] == 8'hF0) && (bus.bus_addr[3:0] < 4'd6);
  assign msk_sel     = (bus.bus_addr[11:4] == 8'hF1) && (bus.bus_addr[3:0] < 4'd6);
  assign sel_idx     = bus.bus_addr[2:0];
  assign bus.bus_hit = fac_sel | msk_sel;

  // Set pulses aligned to the register bit layout
  always_comb begin
    set_bits          = '0;
    set_bits[SRC_CLK] = clock_timer_set;
    set_bits[SRC_SW]  = {2'b00, stopwatch_set};
    set_bits[SRC_PT]  = {3'b000, prog_timer_set};
    set_bits[SRC_SER] = {3'b000, serial_set};
    set_bits[SRC_K0]  = {3'b000, k0_set};
    set_bits[SRC_K1]  = {3'b000, k1_set};
  end

  // Combinational read mux; returns the pre-edge value even on a clearing read
  always_comb begin
    bus.bus_read_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel_idx == SRC_W'(i)) begin
        if (fac_sel) begin
          bus.bus_read_data = factor_q[i];
        end else if (msk_sel) begin
          bus.bus_read_data = mask_q[i];
        end
      end
    end
  end

  // Factor/mask next state; set is applied after the read-clear so set wins
  always_comb begin
    factor_d = factor_q;
    mask_d   = mask_q;
    pending  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.bus_read_req && fac_sel && (sel_idx == SRC_W'(i))) begin
        factor_d[i] = '0;
      end
      factor_d[i] = (factor_d[i] | set_bits[i]) & valid_bits(SRC_W'(i));
      if (bus.bus_write_req && msk_sel && (sel_idx == SRC_W'(i))) begin
        mask_d[i] = bus.bus_write_data & valid_bits(SRC_W'(i));
      end
      pending[i] = |(factor_q[i] & mask_q[i]);
    end
  end

  // Fixed priority: prog timer > serial > K1 > K0 > stopwatch > clock timer
  always_comb begin
    any_pending = |pending;
    best_src    = SRC_CLK;
    if (pending[SRC_PT]) begin
      best_src = SRC_PT;
    end else if (pending[SRC_SER]) begin
      best_src = SRC_SER;
    end else if (pending[SRC_K1]) begin
      best_src = SRC_K1;
    end else if (pending[SRC_K0]) begin
      best_src = SRC_K0;
    end else if (pending[SRC_SW]) begin
      best_src = SRC_SW;
    end
  end

  // Handshake FSM next state; vector is latched only when entering REQUEST
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    vector_d = vector_q;
    case (state_q)
      IDLE: begin
        if (bus.interrupt_enable && any_pending) begin
          state_d  = REQUEST;
          src_d    = best_src;
          vector_d = vector_of(best_src);
        end
      end
      REQUEST: begin
        if (bus.interrupt_ack) begin
          state_d = SERVICE;
        end else if (!bus.interrupt_enable || !pending[src_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (!bus.interrupt_enable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      vector_q <= '0;
      factor_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      vector_q <= vector_d;
      factor_q <= factor_d;
      mask_q   <= mask_d;
    end
  end

  assign bus.interrupt_req    = (state_q == REQUEST);
  assign bus.interrupt_vector = vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: scenario tasks push expected
// values into a scoreboard and compare them against observed DUT outputs.
module tb_interrupt_controller;

`ifdef INTERRUPT_SERIAL_EN
  localparam bit SER = 1'b1;
`else
  localparam bit SER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] clock_timer_set;
  logic [1:0] stopwatch_set;
  logic       prog_timer_set;
  logic       serial_set;
  logic       k0_set;
  logic       k1_set;

  interrupt_controller_if bus_if ();

  interrupt_controller dut (
    .clk             (clk),
    .reset           (reset),
    .clock_timer_set (clock_timer_set),
    .stopwatch_set   (stopwatch_set),
    .prog_timer_set  (prog_timer_set),
    .serial_set      (serial_set),
    .k0_set          (k0_set),
    .k1_set          (k1_set),
    .bus             (bus_if)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  string       name_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string nm, input logic [15:0] v);
    name_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [15:0] v);
    obs_q.push_back(v);
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [3:0] d, output logic hit);
    bus_if.bus_addr     = a;
    bus_if.bus_read_req = 1'b1;
    #1;
    d   = bus_if.bus_read_data;
    hit = bus_if.bus_hit;
    clk_edge();
    bus_if.bus_read_req = 1'b0;
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [3:0] d);
    bus_if.bus_addr       = a;
    bus_if.bus_write_data = d;
    bus_if.bus_write_req  = 1'b1;
    clk_edge();
    bus_if.bus_write_req  = 1'b0;
  endtask

  task automatic pulse_pt();
    prog_timer_set = 1'b1;
    clk_edge();
    prog_timer_set = 1'b0;
  endtask

  task automatic observe_irq();
    observe(16'(bus_if.interrupt_req));
    observe(16'(bus_if.interrupt_vector));
  endtask

  task automatic test_reset();
    logic [3:0] d;
    logic       h;
    logic [15:0] e, o;
    string nm;
    reset = 1'b1;
    prog_timer_set = 1'b1;
    bus_if.bus_addr = 12'hF12;
    bus_if.bus_write_data = 4'hF;
    bus_if.bus_write_req = 1'b1;
    clk_edge();
    clk_edge();
    expect_val("rst_req", 16'h0);     expect_val("rst_vec", 16'h0);
    observe_irq();
    prog_timer_set = 1'b0;
    bus_if.bus_write_req = 1'b0;
    reset = 1'b0;
    clk_edge();
    expect_val("post_rst_req", 16'h0); observe(16'(bus_if.interrupt_req));
    bus_rd(12'hF02, d, h); expect_val("rst_f02", 16'h0);  observe(16'(d));
    bus_rd(12'hF12, d, h); expect_val("rst_f12", 16'h0);  observe(16'(d));
    bus_rd(12'hF05, d, h); expect_val("hit_f05", 16'h1);  observe(16'(h));
    bus_rd(12'hF06, d, h); expect_val("hit_f06", 16'h0);  observe(16'(h));
    expect_val("data_f06", 16'h0); observe(16'(d));
    bus_rd(12'hF15, d, h); expect_val("hit_f15", 16'h1);  observe(16'(h));
    bus_rd(12'hF16, d, h); expect_val("hit_f16", 16'h0);  observe(16'(h));
    bus_rd(12'h000, d, h); expect_val("hit_000", 16'h0);  observe(16'(h));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, o, e); end
    end
  endtask

  task automatic test_basic_request();
    logic [3:0] d;
    logic       h;
    logic [15:0] e, o;
    string nm;
    bus_wr(12'hF12, 4'h1);
    bus_if.interrupt_enable = 1'b1;
    pulse_pt();
    expect_val("lat_req0", 16'h0); observe(16'(bus_if.interrupt_req));
    clk_edge();
    expect_val("lat_req1", 16'h1); expect_val("lat_vec", 16'h010C); observe_irq();
    clk_edge();
    expect_val("hold_req", 16'h1); expect_val("hold_vec", 16'h010C); observe_irq();
    bus_if.interrupt_ack = 1'b1;
    clk_edge();
    bus_if.interrupt_ack = 1'b0;
    expect_val("ack_req", 16'h0); observe(16'(bus_if.interrupt_req));
    clk_edge();
    expect_val("svc_req", 16'h0); observe(16'(bus_if.interrupt_req));
    bus_if.interrupt_enable = 1'b0;
    clk_edge();
    bus_rd(12'hF02, d, h); expect_val("f02_rd1", 16'h1); observe(16'(d));
    bus_rd(12'hF02, d, h); expect_val("f02_rd2", 16'h0); observe(16'(d));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, o, e); end
    end
  endtask

  task automatic test_priority();
    logic [3:0] d;
    logic       h;
    logic [15:0] e, o;
    string nm;
    bus_wr(12'hF10, 4'hF);
    clock_timer_set = 4'b0010;
    prog_timer_set  = 1'b1;
    clk_edge();
    clock_timer_set = 4'b0000;
    prog_timer_set  = 1'b0;
    bus_if.interrupt_enable = 1'b1;
    clk_edge();
    expect_val("prio_req", 16'h1); expect_val("prio_vec_pt", 16'h010C); observe_irq();
    bus_if.interrupt_ack = 1'b1;
    clk_edge();
    bus_if.interrupt_ack = 1'b0;
    bus_if.interrupt_enable = 1'b0;
    clk_edge();
    bus_rd(12'hF02, d, h); expect_val("prio_f02", 16'h1); observe(16'(d));
    bus_if.interrupt_enable = 1'b1;
    clk_edge();
    expect_val("prio_req2", 16'h1); expect_val("prio_vec_clk", 16'h0102); observe_irq();
    pulse_pt();
    clk_edge();
    expect_val("no_preempt_req", 16'h1); expect_val("no_preempt_vec", 16'h0102); observe_irq();
    bus_if.interrupt_ack = 1'b1;
    clk_edge();
    bus_if.interrupt_ack = 1'b0;
    bus_if.interrupt_enable = 1'b0;
    clk_edge();
    bus_rd(12'hF00, d, h); expect_val("prio_f00", 16'h2); observe(16'(d));
    bus_rd(12'hF02, d, h); expect_val("prio_f02b", 16'h1); observe(16'(d));
    bus_rd(12'hF00, d, h); expect_val("prio_f00_clr", 16'h0); observe(16'(d));
    // K1 > K0 > stopwatch, with re-arbitration after the latched source clears
    bus_wr(12'hF11, 4'h3);
    bus_wr(12'hF14, 4'h1);
    bus_wr(12'hF15, 4'h1);
    stopwatch_set = 2'b11; k0_set = 1'b1; k1_set = 1'b1;
    clk_edge();
    stopwatch_set = 2'b00; k0_set = 1'b0; k1_set = 1'b0;
    bus_if.interrupt_enable = 1'b1;
    clk_edge();
    expect_val("vec_k1", 16'h0108); observe(16'(bus_if.interrupt_vector));
    bus_rd(12'hF05, d, h); expect_val("rd_f05", 16'h1); observe(16'(d));
    clk_edge();
    expect_val("k1_gone_req", 16'h0); observe(16'(bus_if.interrupt_req));
    clk_edge();
    expect_val("k0_req", 16'h1); expect_val("vec_k0", 16'h0106); observe_irq();
    bus_rd(12'hF04, d, h);
    clk_edge();
    clk_edge();
    expect_val("sw_req", 16'h1); expect_val("vec_sw", 16'h0104); observe_irq();
    bus_if.interrupt_enable = 1'b0;
    clk_edge();
    bus_rd(12'hF01, d, h); expect_val("rd_f01", 16'h3); observe(16'(d));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, o, e); end
    end
  endtask

  task automatic test_read_clear();
    logic [3:0] d;
    logic       h;
    logic [15:0] e, o;
    string nm;
    pulse_pt();
    bus_if.bus_addr = 12'hF02;
    bus_if.bus_read_req = 1'b1;
    prog_timer_set = 1'b1;
    #1;
    expect_val("rc_same_edge", 16'h1); observe(16'(bus_if.bus_read_data));
    clk_edge();
    bus_if.bus_read_req = 1'b0;
    prog_timer_set = 1'b0;
    bus_rd(12'hF02, d, h); expect_val("rc_set_wins", 16'h1); observe(16'(d));
    bus_rd(12'hF02, d, h); expect_val("rc_cleared", 16'h0); observe(16'(d));
    clock_timer_set = 4'b0001;
    clk_edge();
    bus_if.bus_addr = 12'hF00;
    bus_if.bus_read_req = 1'b1;
    clock_timer_set = 4'b0100;
    #1;
    expect_val("rc_f00_pre", 16'h1); observe(16'(bus_if.bus_read_data));
    clk_edge();
    bus_if.bus_read_req = 1'b0;
    clock_timer_set = 4'b0000;
    bus_rd(12'hF00, d, h); expect_val("rc_f00_post", 16'h4); observe(16'(d));
    bus_rd(12'hF00, d, h); expect_val("rc_f00_clr", 16'h0); observe(16'(d));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, o, e); end
    end
  endtask

  task automatic test_mask();
    logic [3:0] d;
    logic       h;
    int         high_cnt;
    logic [15:0] e, o;
    string nm;
    bus_wr(12'hF12, 4'h0);
    bus_if.interrupt_enable = 1'b1;
    pulse_pt();
    high_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      clk_edge();
      if (bus_if.interrupt_req === 1'b1) high_cnt++;
    end
    expect_val("masked_req_cycles", 16'h0); observe(16'(high_cnt));
    bus_rd(12'hF12, d, h); expect_val("mask_f12_rd", 16'h0); observe(16'(d));
    bus_wr(12'hF12, 4'h1);
    clk_edge();
    expect_val("unmask_req", 16'h1); expect_val("unmask_vec", 16'h010C); observe_irq();
    bus_wr(12'hF12, 4'h0);
    expect_val("remask_req_hold", 16'h1); observe(16'(bus_if.interrupt_req));
    clk_edge();
    expect_val("remask_req_drop", 16'h0); observe(16'(bus_if.interrupt_req));
    bus_if.interrupt_enable = 1'b0;
    bus_wr(12'hF02, 4'h0);
    bus_wr(12'hF00, 4'hF);
    bus_rd(12'hF00, d, h); expect_val("wr_f00_ignored", 16'h0); observe(16'(d));
    bus_rd(12'hF02, d, h); expect_val("wr_f02_ignored", 16'h1); observe(16'(d));
    bus_wr(12'hF11, 4'hF);
    bus_rd(12'hF11, d, h); expect_val("mask_f11_bits", 16'h3); observe(16'(d));
    bus_wr(12'hF14, 4'hF);
    bus_rd(12'hF14, d, h); expect_val("mask_f14_bits", 16'h1); observe(16'(d));
    bus_wr(12'hF10, 4'h5);
    bus_rd(12'hF10, d, h); expect_val("mask_f10_rw", 16'h5); observe(16'(d));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, o, e); end
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] d;
    logic       h;
    logic [15:0] e, o;
    string nm;
    bus_wr(12'hF12, 4'h1);
    bus_if.interrupt_enable = 1'b1;
    pulse_pt();
    clk_edge();
    expect_val("ed_req", 16'h1); expect_val("ed_vec", 16'h010C); observe_irq();
    bus_if.interrupt_enable = 1'b0;
    clk_edge();
    expect_val("ed_drop_req", 16'h0); observe(16'(bus_if.interrupt_req));
    bus_if.interrupt_enable = 1'b1;
    clk_edge();
    expect_val("ed_reissue_req", 16'h1); expect_val("ed_reissue_vec", 16'h010C); observe_irq();
    reset = 1'b1;
    clk_edge();
    expect_val("abort_req", 16'h0); expect_val("abort_vec", 16'h0); observe_irq();
    reset = 1'b0;
    clk_edge();
    clk_edge();
    expect_val("abort_after_req", 16'h0); observe(16'(bus_if.interrupt_req));
    bus_rd(12'hF12, d, h); expect_val("abort_mask", 16'h0); observe(16'(d));
    bus_if.interrupt_ack = 1'b1;
    clk_edge();
    bus_if.interrupt_ack = 1'b0;
    bus_wr(12'hF12, 4'h1);
    pulse_pt();
    clk_edge();
    expect_val("stray_ack_req", 16'h1); expect_val("stray_ack_vec", 16'h010C); observe_irq();
    bus_if.interrupt_ack = 1'b1;
    clk_edge();
    bus_if.interrupt_ack = 1'b0;
    reset = 1'b1;
    clk_edge();
    reset = 1'b0;
    clk_edge();
    expect_val("svc_abort_req", 16'h0); expect_val("svc_abort_vec", 16'h0); observe_irq();
    bus_if.interrupt_enable = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, o, e); end
    end
  endtask

  task automatic test_serial_cfg();
    logic [3:0] d;
    logic       h;
    logic [15:0] e, o;
    string nm;
    bus_wr(12'hF13, 4'h1);
    bus_if.interrupt_enable = 1'b1;
    serial_set = 1'b1;
    clk_edge();
    serial_set = 1'b0;
    clk_edge();
    clk_edge();
    expect_val("ser_req", 16'(SER));
    expect_val("ser_vec", SER ? 16'h010A : 16'h0000);
    observe_irq();
    bus_rd(12'hF13, d, h);
    expect_val("ser_f13", 16'(SER)); observe(16'(d));
    expect_val("ser_f13_hit", 16'h1); observe(16'(h));
    bus_rd(12'hF03, d, h);
    expect_val("ser_f03", 16'(SER)); observe(16'(d));
    expect_val("ser_f03_hit", 16'h1); observe(16'(h));
    bus_if.interrupt_enable = 1'b0;
    clk_edge();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, o, e); end
    end
  endtask

  initial begin
    reset                   = 1'b1;
    clock_timer_set         = 4'b0000;
    stopwatch_set           = 2'b00;
    prog_timer_set          = 1'b0;
    serial_set              = 1'b0;
    k0_set                  = 1'b0;
    k1_set                  = 1'b0;
    bus_if.bus_addr         = 12'h000;
    bus_if.bus_read_req     = 1'b0;
    bus_if.bus_write_req    = 1'b0;
    bus_if.bus_write_data   = 4'h0;
    bus_if.interrupt_enable = 1'b0;
    bus_if.interrupt_ack    = 1'b0;
    clk_edge();
    test_reset();
    test_basic_request();
    test_priority();
    test_read_clear();
    test_mask();
    test_enable_drop();
    test_serial_cfg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
